// File: rtl/mul_seq32_pkg.sv
// Shared constants and state encoding for the sequential 32x32 multiplier.
package mul_seq32_pkg;

    // Width of the CLA that the multiplier is built around (fixed).
    localparam int CLA_W = 32;

    // Iteration counter width and terminal count (32 iterations per product).
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, lookahead chained across groups.
module adder_cla32 (
    input  logic [31:0] i_A,
    input  logic [31:0] i_B,
    input  logic        i_Cin,
    output logic [31:0] o_S,
    output logic        o_Cout
);

    logic [31:0] gen;
    logic [31:0] prop;

    assign gen  = i_A & i_B;
    assign prop = i_A ^ i_B;

    // Group carries are carried in a block-local variable so each group sees a settled carry-in.
    always_comb begin
        logic cg;
        logic c1, c2, c3;
        logic grp_g, grp_p;
        int   b;
        o_S = '0;
        cg  = i_Cin;
        for (int k = 0; k < 8; k++) begin
            b  = 4 * k;
            c1 = gen[b] | (prop[b] & cg);
            c2 = gen[b+1] | (prop[b+1] & gen[b]) | (prop[b+1] & prop[b] & cg);
            c3 = gen[b+2] | (prop[b+2] & gen[b+1]) | (prop[b+2] & prop[b+1] & gen[b])
               | (prop[b+2] & prop[b+1] & prop[b] & cg);
            o_S[b]   = prop[b]   ^ cg;
            o_S[b+1] = prop[b+1] ^ c1;
            o_S[b+2] = prop[b+2] ^ c2;
            o_S[b+3] = prop[b+3] ^ c3;
            grp_g = gen[b+3] | (prop[b+3] & gen[b+2]) | (prop[b+3] & prop[b+2] & gen[b+1])
                  | (prop[b+3] & prop[b+2] & prop[b+1] & gen[b]);
            grp_p = prop[b+3] & prop[b+2] & prop[b+1] & prop[b];
            cg    = grp_g | (grp_p & cg);
        end
        o_Cout = cg;
    end

endmodule

// File: rtl/mul_seq32.sv
// Sequential unsigned 32x32->64 shift-add multiplier with valid/ready on both sides.
// One product in flight; 32 iterations, each adding (P[0] ? A : 0) to the upper half of P.
module mul_seq32
    import mul_seq32_pkg::*;
#(
    parameter int BW_DATA = CLA_W
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [BW_DATA-1:0]   i_A,
    input  logic [BW_DATA-1:0]   i_B,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*BW_DATA-1:0] o_P
);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [BW_DATA-1:0]   a_reg;
    logic [2*BW_DATA-1:0] p_reg;

    logic [BW_DATA-1:0]   add_b;
    logic [BW_DATA-1:0]   add_sum;
    logic                 add_cout;

    // Addend is the multiplicand when the current multiplier bit (P[0]) is set.
    assign add_b = p_reg[0] ? a_reg : '0;

    adder_cla32 u_adder_cla32 (
        .i_A    (p_reg[2*BW_DATA-1:BW_DATA]),
        .i_B    (add_b),
        .i_Cin  (1'b0),
        .o_S    (add_sum),
        .o_Cout (add_cout)
    );

    // State register; reset abandons any product in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state: accept in IDLE, 32 iterations in BUSY, wait for consumer in DONE.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = i_valid ? S_BUSY : S_IDLE;
            S_BUSY:  state_nxt = (cnt == CNT_LAST) ? S_DONE : S_BUSY;
            S_DONE:  state_nxt = i_ready ? S_IDLE : S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs; product is gated to zero whenever it is not valid.
    always_comb begin
        o_ready = (state == S_IDLE);
        o_valid = (state == S_DONE);
        o_P     = o_valid ? p_reg : '0;
    end

    // Datapath: load operands on accept, then shift-add once per BUSY cycle.
    // The adder carry-out lands in P's MSB so the 64-bit product never overflows.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt   <= '0;
            a_reg <= '0;
            p_reg <= '0;
        end else if (state == S_IDLE && i_valid) begin
            cnt   <= '0;
            a_reg <= i_A;
            p_reg <= {{BW_DATA{1'b0}}, i_B};
        end else if (state == S_BUSY) begin
            cnt   <= cnt + 1'b1;
            p_reg <= {add_cout, add_sum, p_reg[BW_DATA-1:1]};
        end
    end

endmodule
